// File: rtl/tile_n_planner.sv
// tile_n_planner: computes the largest tile count whose activations, weights,
// bias and partial sums fit in the global buffer, using a bit-serial
// restoring divider. Handshake: start / busy / done.
// Optional feature macro: TILE_N_CLAMP_EN (clamps the quotient to TILE_N_MAX
// before alignment). The default build has no clamp.

`ifndef GLB_MAX_BYTES
`define GLB_MAX_BYTES 65536
`endif
`ifndef BYTES_I
`define BYTES_I 1
`endif
`ifndef BYTES_W
`define BYTES_W 1
`endif
`ifndef BYTES_P
`define BYTES_P 4
`endif

module tile_n_planner #(
  parameter int unsigned GLB_BYTES  = `GLB_MAX_BYTES,
  parameter int unsigned BYTES_I    = `BYTES_I,
  parameter int unsigned BYTES_W    = `BYTES_W,
  parameter int unsigned BYTES_P    = `BYTES_P,
  parameter int unsigned DIM_W      = 7,
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned ALIGN_N    = 4,
  parameter int unsigned TILE_N_MAX = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       layer_type,
  input  logic [DIM_W-1:0] in_C,
  input  logic [DIM_W-1:0] out_C,
  input  logic [1:0]       kH,
  input  logic [1:0]       kW,
  input  logic [DIM_W-1:0] tile_D,
  input  logic [DIM_W-1:0] tile_K,
  input  logic [DIM_W-1:0] tile_D_f,
  input  logic [DIM_W-1:0] tile_K_f,
  input  logic [DIM_W-1:0] M1,
  input  logic [DIM_W-1:0] M2,
  input  logic [DIM_W-1:0] M3,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] tile_n,
  output logic             err
);

  localparam int unsigned PW = OUT_W + 2;         // product / budget width
  localparam int unsigned RW = PW + 1;            // shifted remainder width
  localparam int unsigned CW = $clog2(OUT_W + 1); // divider step counter

  localparam logic [1:0] LT_PW  = 2'd0;
  localparam logic [1:0] LT_LIN = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CHECK,
    S_DIV,
    S_FIN
  } state_t;

  state_t state, state_nx;

  // Control strobes from the FSM
  logic cap_en, prep_en, check_en, div_en, fin_en;

  // Captured request
  logic [1:0]       lt_r, kh_r, kw_r;
  logic [DIM_W-1:0] inc_r, outc_r, td_r, tk_r, tdf_r, tkf_r, m1_r, m2_r, m3_r;

  // Budget terms and divider state
  logic [PW-1:0]    f_q, b_q, p_q, d_q;
  logic [PW-1:0]    n_val;
  logic             bad;
  logic             err_flag;
  logic [OUT_W-1:0] quo;
  logic [PW-1:0]    rem;
  logic [RW-1:0]    rem_sh, rem_nx;
  logic             ge;
  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] q_cl, aligned;

  // Remaining budget after fixed costs; negative or zero divisor is infeasible
  assign n_val = PW'(GLB_BYTES) - f_q - b_q + p_q;
  assign bad   = n_val[PW-1] || (d_q == '0);

  // One restoring-division step: shift in next dividend bit, try subtract
  always_comb begin
    rem_sh = {rem, quo[OUT_W-1]};
    ge     = (rem_sh >= RW'(d_q));
    rem_nx = ge ? (rem_sh - RW'(d_q)) : rem_sh;
  end

  // Optional clamp, then per-layer-type alignment
  always_comb begin
`ifdef TILE_N_CLAMP_EN
    q_cl = (quo > OUT_W'(TILE_N_MAX)) ? OUT_W'(TILE_N_MAX) : quo;
`else
    q_cl = quo;
`endif
    if ((lt_r == LT_PW) || (lt_r == LT_LIN)) aligned = q_cl & ~OUT_W'(ALIGN_N - 1);
    else                                      aligned = q_cl;
  end

  // Channel counts travel with the request but do not enter the arithmetic
  logic unused_ok;
`ifdef TILE_N_CLAMP_EN
  assign unused_ok = ^{inc_r, outc_r};
`else
  assign unused_ok = ^{inc_r, outc_r, OUT_W'(TILE_N_MAX)};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and control strobes; start is blocked during the done cycle
  always_comb begin
    state_nx = state;
    cap_en   = 1'b0;
    prep_en  = 1'b0;
    check_en = 1'b0;
    div_en   = 1'b0;
    fin_en   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !done) begin
          cap_en   = 1'b1;
          state_nx = S_PREP;
        end
      end
      S_PREP: begin
        prep_en  = 1'b1;
        state_nx = S_CHECK;
      end
      S_CHECK: begin
        check_en = 1'b1;
        state_nx = bad ? S_FIN : S_DIV;
      end
      S_DIV: begin
        div_en = 1'b1;
        if (cnt == CW'(OUT_W - 1)) state_nx = S_FIN;
      end
      S_FIN: begin
        fin_en   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt_r     <= '0;
      kh_r     <= '0;
      kw_r     <= '0;
      inc_r    <= '0;
      outc_r   <= '0;
      td_r     <= '0;
      tk_r     <= '0;
      tdf_r    <= '0;
      tkf_r    <= '0;
      m1_r     <= '0;
      m2_r     <= '0;
      m3_r     <= '0;
      f_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      d_q      <= '0;
      err_flag <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tile_n   <= '0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cap_en) begin
        lt_r   <= layer_type;
        kh_r   <= kH;
        kw_r   <= kW;
        inc_r  <= in_C;
        outc_r <= out_C;
        td_r   <= tile_D;
        tk_r   <= tile_K;
        tdf_r  <= tile_D_f;
        tkf_r  <= tile_K_f;
        m1_r   <= M1;
        m2_r   <= M2;
        m3_r   <= M3;
        busy   <= 1'b1;
      end
      if (prep_en) begin
        f_q <= PW'(kh_r) * PW'(kw_r) * PW'(tdf_r) * PW'(tkf_r) * PW'(BYTES_W);
        b_q <= PW'(tk_r) * PW'(BYTES_P);
        p_q <= PW'(m2_r) * PW'(m3_r) * PW'(tk_r) * PW'(BYTES_P);
        d_q <= PW'(m1_r) * PW'(td_r) * PW'(BYTES_I)
             + PW'(m3_r) * PW'(tk_r) * PW'(BYTES_P);
      end
      if (check_en) begin
        err_flag <= bad;
        cnt      <= '0;
        rem      <= '0;
        if (|n_val[PW-1:OUT_W]) quo <= '1;
        else                    quo <= n_val[OUT_W-1:0];
      end
      if (div_en) begin
        rem <= PW'(rem_nx);
        quo <= {quo[OUT_W-2:0], ge};
        cnt <= cnt + CW'(1);
      end
      if (fin_en) begin
        done   <= 1'b1;
        busy   <= 1'b0;
        err    <= err_flag;
        tile_n <= err_flag ? '0 : aligned;
      end
    end
  end

endmodule

// File: tb/tb_tile_n_planner.sv
// Self-checking bench for tile_n_planner (scoreboard of expected results).
module tb_tile_n_planner;

  localparam int unsigned TMAX = 256;

  logic        clk, rst_n, start;
  logic [1:0]  layer_type, kH, kW;
  logic [6:0]  in_C, out_C, tile_D, tile_K, tile_D_f, tile_K_f, M1, M2, M3;
  logic        busy, done, err;
  logic [31:0] tile_n;

  tile_n_planner #(
    .GLB_BYTES(65536), .BYTES_I(1), .BYTES_W(1), .BYTES_P(4),
    .DIM_W(7), .OUT_W(32), .ALIGN_N(4), .TILE_N_MAX(TMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer_type(layer_type),
    .in_C(in_C), .out_C(out_C), .kH(kH), .kW(kW),
    .tile_D(tile_D), .tile_K(tile_K), .tile_D_f(tile_D_f), .tile_K_f(tile_K_f),
    .M1(M1), .M2(M2), .M3(M3),
    .busy(busy), .done(done), .tile_n(tile_n), .err(err)
  );

  typedef struct {
    logic [31:0] tile;
    logic        e;
    int          when;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every done must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL spurious_done at cycle %0d tile_n=%0d", cyc, tile_n);
      end else begin
        exp_t x;
        x = sb.pop_front();
        checks++;
        if (tile_n !== x.tile) $display("FAIL tile_n got %0d exp %0d", tile_n, x.tile);
        else passes++;
        checks++;
        if (err !== x.e) $display("FAIL err got %0b exp %0b", err, x.e);
        else passes++;
        checks++;
        if (cyc !== x.when) $display("FAIL done_cycle got %0d exp %0d", cyc, x.when);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL busy_in_done got %0b exp 0", busy);
        else passes++;
      end
    end
  end

  // Independent reference: plain arithmetic with a real divide
  task automatic model(input logic [1:0] lt, input int kh, kw, tdf, tkf, td, tk, m1, m2, m3,
                       output logic [31:0] t, output logic e);
    longint f, b, p, d, n, q;
    f = longint'(kh) * kw * tdf * tkf;
    b = longint'(tk) * 4;
    p = longint'(m2) * m3 * tk * 4;
    d = longint'(m1) * td + longint'(m3) * tk * 4;
    n = 65536 - f - b + p;
    if (n < 0 || d == 0) begin
      t = 0; e = 1'b1;
    end else begin
      if (n > 64'hFFFF_FFFF) n = 64'hFFFF_FFFF;
      q = n / d;
`ifdef TILE_N_CLAMP_EN
      if (q > TMAX) q = TMAX;
`endif
      if (lt == 2'd0 || lt == 2'd3) q = q - (q % 4);
      t = 32'(q); e = 1'b0;
    end
  endtask

  task automatic scramble();
    layer_type = 2'($urandom); kH = 2'($urandom); kW = 2'($urandom);
    tile_D = 7'($urandom); tile_K = 7'($urandom);
    tile_D_f = 7'($urandom); tile_K_f = 7'($urandom);
    M1 = 7'($urandom); M2 = 7'($urandom); M3 = 7'($urandom);
    in_C = 7'($urandom); out_C = 7'($urandom);
  endtask

  // Drive one request at a negedge; inputs are scrambled right after accept
  task automatic launch(input logic [1:0] lt, input logic [1:0] kh, kw,
                        input logic [6:0] tdf, tkf, td, tk, m1, m2, m3,
                        input logic [31:0] et, input logic ee, input bit push);
    exp_t x;
    @(negedge clk);
    layer_type = lt; kH = kh; kW = kw; tile_D_f = tdf; tile_K_f = tkf;
    tile_D = td; tile_K = tk; M1 = m1; M2 = m2; M3 = m3;
    in_C = 7'd64; out_C = 7'd64;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_after_accept got %0b exp 1", busy);
    else passes++;
    if (push) begin
      x.tile = et; x.e = ee; x.when = cyc + (ee ? 3 : 35);
      sb.push_back(x);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL timeout pending=%0d", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks += 4;
    if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else passes++;
    if (done !== 1'b0) $display("FAIL reset_done got %0b exp 0", done); else passes++;
    if (tile_n !== 32'd0) $display("FAIL reset_tile_n got %0d exp 0", tile_n); else passes++;
    if (err !== 1'b0) $display("FAIL reset_err got %0b exp 0", err); else passes++;
  endtask

  task automatic test_pw();
`ifdef TILE_N_CLAMP_EN
    launch(2'd0, 2'd1, 2'd1, 7'd32, 7'd32, 7'd32, 7'd32, 7'd1, 7'd1, 7'd1, 32'd256, 1'b0, 1'b1);
`else
    launch(2'd0, 2'd1, 2'd1, 7'd32, 7'd32, 7'd32, 7'd32, 7'd1, 7'd1, 7'd1, 32'd400, 1'b0, 1'b1);
`endif
    wait_idle();
  endtask

  task automatic test_dw();
`ifdef TILE_N_CLAMP_EN
    launch(2'd1, 2'd1, 2'd1, 7'd32, 7'd32, 7'd32, 7'd32, 7'd1, 7'd1, 7'd1, 32'd256, 1'b0, 1'b1);
`else
    launch(2'd1, 2'd1, 2'd1, 7'd32, 7'd32, 7'd32, 7'd32, 7'd1, 7'd1, 7'd1, 32'd403, 1'b0, 1'b1);
`endif
    wait_idle();
  endtask

  task automatic test_errors();
    launch(2'd2, 2'd3, 2'd3, 7'd127, 7'd127, 7'd32, 7'd32, 7'd1, 7'd1, 7'd1, 32'd0, 1'b1, 1'b1);
    wait_idle();
    launch(2'd1, 2'd1, 2'd1, 7'd32, 7'd32, 7'd32, 7'd32, 7'd0, 7'd1, 7'd0, 32'd0, 1'b1, 1'b1);
    wait_idle();
  endtask

  task automatic test_busy_ignore();
    launch(2'd0, 2'd1, 2'd1, 7'd32, 7'd32, 7'd32, 7'd32, 7'd1, 7'd1, 7'd1,
`ifdef TILE_N_CLAMP_EN
           32'd256,
`else
           32'd400,
`endif
           1'b0, 1'b1);
    repeat (9) @(negedge clk);
    layer_type = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    launch(2'd3, 2'd1, 2'd1, 7'd32, 7'd32, 7'd32, 7'd32, 7'd1, 7'd1, 7'd1,
`ifdef TILE_N_CLAMP_EN
           32'd256,
`else
           32'd400,
`endif
           1'b0, 1'b1);
    repeat (36) @(negedge clk);
    checks++;
    if (done !== 1'b1) $display("FAIL done_cycle_probe got %0b exp 1", done); else passes++;
    start = 1'b1; layer_type = 2'd1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL start_in_done_accepted busy=%0b exp 0", busy); else passes++;
    launch(2'd1, 2'd1, 2'd1, 7'd32, 7'd32, 7'd32, 7'd32, 7'd1, 7'd1, 7'd1,
`ifdef TILE_N_CLAMP_EN
           32'd256,
`else
           32'd403,
`endif
           1'b0, 1'b1);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    launch(2'd1, 2'd1, 2'd1, 7'd32, 7'd32, 7'd32, 7'd32, 7'd1, 7'd1, 7'd1, 32'd0, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (busy !== 1'b0) $display("FAIL midreset_busy got %0b exp 0", busy); else passes++;
    if (tile_n !== 32'd0) $display("FAIL midreset_tile_n got %0d exp 0", tile_n); else passes++;
    if (err !== 1'b0) $display("FAIL midreset_err got %0b exp 0", err); else passes++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    test_pw();
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  lt, kh, kw;
      logic [6:0]  tdf, tkf, td, tk, m1, m2, m3;
      logic [31:0] et;
      logic        ee;
      lt = 2'($urandom); kh = 2'($urandom); kw = 2'($urandom);
      tdf = 7'($urandom_range(1, 60)); tkf = 7'($urandom_range(1, 60));
      td = 7'($urandom_range(0, 127)); tk = 7'($urandom_range(0, 127));
      m1 = 7'($urandom_range(0, 3)); m2 = 7'($urandom_range(0, 3)); m3 = 7'($urandom_range(0, 3));
      model(lt, int'(kh), int'(kw), int'(tdf), int'(tkf), int'(td), int'(tk),
            int'(m1), int'(m2), int'(m3), et, ee);
      launch(lt, kh, kw, tdf, tkf, td, tk, m1, m2, m3, et, ee, 1'b1);
      wait_idle();
    end
  endtask

  initial begin
    test_reset();
    test_pw();
    test_dw();
    test_errors();
    test_pw();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
